// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned MODE_MEALY = 0;
  localparam int unsigned MODE_MOORE = 1;

  // Bits needed to represent a prefix length of 0..width.
  function automatic int unsigned PROG_W(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_prefix_len.sv
// Longest suffix of the filled history that equals a leading prefix of the pattern.
module seq_prefix_len
  import seq_detect_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         i_hist,
  input  logic [WIDTH-1:0]         i_pat,
  input  logic [PROG_W(WIDTH)-1:0] i_fill,
  output logic [PROG_W(WIDTH)-1:0] o_len
);

  localparam int unsigned PW = PROG_W(WIDTH);

  // Later (longer) hits overwrite earlier ones, leaving the longest k.
  always_comb begin
    o_len = '0;
    for (int unsigned k = 1; k <= WIDTH; k++) begin
      if ((PW'(k) <= i_fill) &&
          ((((i_pat >> (WIDTH - k)) ^ i_hist) & ({WIDTH{1'b1}} >> (WIDTH - k))) == '0)) begin
        o_len = PW'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector with loadable pattern, Mealy/Moore output and saturating match count.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODE    = 0,
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     x,
  input  logic                     load,
  input  logic [WIDTH-1:0]         pat,
  output logic                     y,
  output logic [PROG_W(WIDTH)-1:0] prog,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int unsigned PW = PROG_W(WIDTH);
  localparam logic [PW-1:0] FillFull = PW'(WIDTH);

  logic [WIDTH-1:0] r_pat, r_hist;
  logic [WIDTH-1:0] w_pat_d, w_hist_d, w_hist_shift;
  logic [PW-1:0]    r_fill, w_fill_d, w_fill_inc, w_prefix;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_moore_y, w_moore_y_d, w_match;

  seq_prefix_len #(
    .WIDTH (WIDTH)
  ) u_prefix (
    .i_hist (r_hist),
    .i_pat  (r_pat),
    .i_fill (r_fill),
    .o_len  (w_prefix)
  );

  always_comb begin
    w_hist_shift = {r_hist[WIDTH-2:0], x};
    w_fill_inc   = (r_fill == FillFull) ? FillFull : r_fill + PW'(1);
    w_match      = en & ~load & (w_hist_shift == r_pat) & (w_fill_inc == FillFull);

    w_pat_d     = r_pat;
    w_hist_d    = r_hist;
    w_fill_d    = r_fill;
    w_cnt_d     = r_cnt;
    w_moore_y_d = 1'b0;

    if (load) begin
      // The x bit presented alongside load is discarded.
      w_pat_d  = pat;
      w_hist_d = '0;
      w_fill_d = '0;
      w_cnt_d  = '0;
    end else begin
      w_moore_y_d = w_match;
      if (en) begin
        if (w_match && (OVERLAP == 0)) begin
          w_hist_d = '0;
          w_fill_d = '0;
        end else begin
          w_hist_d = w_hist_shift;
          w_fill_d = w_fill_inc;
        end
        if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat     <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_moore_y <= 1'b0;
    end else begin
      r_pat     <= w_pat_d;
      r_hist    <= w_hist_d;
      r_fill    <= w_fill_d;
      r_cnt     <= w_cnt_d;
      r_moore_y <= w_moore_y_d;
    end
  end

  // A completing bit reports the full length before history is shifted in.
  assign prog      = w_match ? FillFull : w_prefix;
  assign y         = (MODE == MODE_MOORE) ? r_moore_y : w_match;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect across Mealy/Moore, overlap and saturation variants.
module tb_seq_detect;

  logic       clk, rst, en, x, load;
  logic [3:0] pat;
  logic       y_ov, y_no, y_mo;
  logic [2:0] prog_ov, prog_no, prog_mo;
  logic [7:0] cnt_ov, cnt_no, cnt_mo;

  logic       s_en, s_x, s_load;
  logic [1:0] s_pat, s_prog, s_cnt;
  logic       s_y;

  int checks = 0;
  int errors = 0;

  seq_detect #(.WIDTH(4), .MODE(0), .OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat(pat),
    .y(y_ov), .prog(prog_ov), .match_cnt(cnt_ov)
  );

  seq_detect #(.WIDTH(4), .MODE(0), .OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat(pat),
    .y(y_no), .prog(prog_no), .match_cnt(cnt_no)
  );

  seq_detect #(.WIDTH(4), .MODE(1), .OVERLAP(1), .CNT_W(8)) u_mo (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat(pat),
    .y(y_mo), .prog(prog_mo), .match_cnt(cnt_mo)
  );

  seq_detect #(.WIDTH(2), .MODE(0), .OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(s_en), .x(s_x), .load(s_load), .pat(s_pat),
    .y(s_y), .prog(s_prog), .match_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic b);
    @(negedge clk);
    load = 1'b0;
    en   = e;
    x    = b;
    #1;
  endtask

  task automatic do_load(input logic [3:0] p);
    @(negedge clk);
    load = 1'b1;
    pat  = p;
    en   = 1'b1;
    x    = 1'b1;
    #1;
  endtask

  task automatic sat_step(input logic e, input logic b);
    @(negedge clk);
    s_load = 1'b0;
    s_en   = e;
    s_x    = b;
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; x = 1'b0; load = 1'b0; pat = 4'b0000;
    s_en = 1'b0; s_x = 1'b0; s_load = 1'b0; s_pat = 2'b00;
    #2;
    chk("rst_y", y_ov, 0);
    chk("rst_prog", prog_ov, 0);
    chk("rst_cnt", cnt_ov, 0);
    chk("rst_y_moore", y_mo, 0);
    @(negedge clk);
    rst = 1'b1;

    // Overlapping / non-overlapping / Moore on stream 1,0,1,1,0,1,1
    do_load(4'b1011);
    chk("load_y_ov", y_ov, 0);
    chk("load_y_no", y_no, 0);
    step(1, 1); chk("b1_prog", prog_ov, 0); chk("b1_y", y_ov, 0);
    step(1, 0); chk("b2_prog", prog_ov, 1); chk("b2_y", y_ov, 0);
    step(1, 1); chk("b3_prog", prog_ov, 2); chk("b3_y", y_ov, 0);
    step(1, 1);
    chk("b4_y_ov", y_ov, 1); chk("b4_prog_ov", prog_ov, 4);
    chk("b4_y_no", y_no, 1); chk("b4_y_mo", y_mo, 0); chk("b4_cnt_ov", cnt_ov, 0);
    step(1, 0);
    chk("b5_y_ov", y_ov, 0); chk("b5_y_mo", y_mo, 1); chk("b5_cnt_ov", cnt_ov, 1);
    chk("b5_prog_no", prog_no, 0); chk("b5_cnt_no", cnt_no, 1); chk("b5_prog_ov", prog_ov, 4);
    step(1, 1);
    chk("b6_prog_ov", prog_ov, 2); chk("b6_y_mo", y_mo, 0); chk("b6_prog_no", prog_no, 0);
    step(1, 1);
    chk("b7_y_ov", y_ov, 1); chk("b7_prog_ov", prog_ov, 4);
    chk("b7_y_no", y_no, 0); chk("b7_prog_no", prog_no, 1);
    step(0, 0);
    chk("i1_y_ov", y_ov, 0); chk("i1_y_mo", y_mo, 1); chk("i1_cnt_ov", cnt_ov, 2);
    chk("i1_cnt_no", cnt_no, 1); chk("i1_cnt_mo", cnt_mo, 2); chk("i1_y_no", y_no, 0);
    step(0, 1);
    chk("i2_y_mo", y_mo, 0); chk("i2_y_ov", y_ov, 0); chk("i2_prog_ov", prog_ov, 4);

    // Enable gap holds progress; pat changes without load are ignored
    do_load(4'b1011);
    step(1, 1); chk("g1_cnt", cnt_ov, 0); chk("g1_prog", prog_ov, 0); chk("g1_y_mo", y_mo, 0);
    step(1, 0); chk("g2_prog", prog_ov, 1);
    step(1, 1); chk("g3_prog", prog_ov, 2);
    step(0, 1); pat = 4'b0000; #1;
    chk("gap1_prog", prog_ov, 3); chk("gap1_y", y_ov, 0);
    step(0, 0); chk("gap2_prog", prog_ov, 3); chk("gap2_y", y_ov, 0);
    step(0, 1); chk("gap3_prog", prog_ov, 3); chk("gap3_y", y_ov, 0); chk("gap3_y_mo", y_mo, 0);
    step(1, 1); chk("g4_y", y_ov, 1); chk("g4_prog", prog_ov, 4);
    step(0, 0); chk("g5_y_mo", y_mo, 1); chk("g5_cnt", cnt_ov, 1);

    // Asynchronous reset in the middle of a cycle
    step(1, 1);
    step(1, 0);
    step(1, 1);
    @(posedge clk);
    #1 en = 1'b0;
    #1;
    chk("pre_rst_prog", prog_ov, 3); chk("pre_rst_cnt", cnt_ov, 1);
    rst = 1'b0;
    #1;
    chk("arst_prog", prog_ov, 0); chk("arst_y", y_ov, 0); chk("arst_cnt", cnt_ov, 0);
    chk("arst_cnt_no", cnt_no, 0); chk("arst_y_mo", y_mo, 0);
    @(negedge clk);
    rst = 1'b1;
    do_load(4'b1011);
    step(1, 1); chk("r1_prog", prog_ov, 0); chk("r1_y", y_ov, 0);
    step(1, 0); chk("r2_prog", prog_ov, 1); chk("r2_y", y_ov, 0);
    step(1, 1); chk("r3_prog", prog_ov, 2); chk("r3_y", y_ov, 0);
    step(1, 1); chk("r4_y", y_ov, 1); chk("r4_prog", prog_ov, 4);
    step(0, 0); chk("r5_y", y_ov, 0); chk("r5_cnt", cnt_ov, 1); chk("r5_y_mo", y_mo, 1);
    step(0, 0); chk("r6_y_mo", y_mo, 0);

    // Saturating counter, WIDTH=2, pat=11, six 1s
    @(negedge clk);
    s_load = 1'b1; s_pat = 2'b11; s_en = 1'b1; s_x = 1'b1;
    #1;
    chk("s_load_y", s_y, 0);
    sat_step(1, 1); chk("s1_y", s_y, 0); chk("s1_cnt", s_cnt, 0); chk("s1_prog", s_prog, 0);
    sat_step(1, 1); chk("s2_y", s_y, 1); chk("s2_cnt", s_cnt, 0); chk("s2_prog", s_prog, 2);
    sat_step(1, 1); chk("s3_y", s_y, 1); chk("s3_cnt", s_cnt, 1);
    sat_step(1, 1); chk("s4_y", s_y, 1); chk("s4_cnt", s_cnt, 2);
    sat_step(1, 1); chk("s5_y", s_y, 1); chk("s5_cnt", s_cnt, 3);
    sat_step(1, 1); chk("s6_y", s_y, 1); chk("s6_cnt", s_cnt, 3);
    sat_step(0, 0); chk("s7_y", s_y, 0); chk("s7_cnt", s_cnt, 3); chk("s7_prog", s_prog, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect.md
SEQ_DETECT -- requirements
Module: seq_detect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter MODE, default 0: 0 = Mealy output, 1 = Moore output.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 = overlapping matches counted, 0 = history cleared after each match.
REQ-004 The block SHALL have parameter CNT_W, default 8: match counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: x is sampled only in cycles where en=1.
REQ-008 The block SHALL have port x, input, 1 bit: serial data bit.
REQ-009 The block SHALL have port load, input, 1 bit: captures pat and restarts detection.
REQ-010 The block SHALL have port pat, input, WIDTH bits: pattern; pat[WIDTH-1] is the first bit expected.
REQ-011 The block SHALL have port y, output, 1 bit: match indication.
REQ-012 The block SHALL have port prog, output, $clog2(WIDTH+1) bits: current matched-prefix length, 0..WIDTH.
REQ-013 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-014 The block SHALL hold a pattern register, a WIDTH-bit history shift register, and a fill count 0..WIDTH.
REQ-015 On en=1 and load=0, the block SHALL update history to {history[WIDTH-2:0], x} and set fill to min(fill+1, WIDTH).
REQ-016 A match SHALL occur when the updated history equals the pattern register and the updated fill equals WIDTH.
REQ-017 With MODE=0, y SHALL be combinational, equal to 1 in the same cycle as the en=1 bit that completes a match, and 0 otherwise.
REQ-018 With MODE=1, y SHALL be registered and high for exactly one cycle: the cycle after the completing bit.
REQ-019 With OVERLAP=0, a match SHALL reset fill to 0 and history to 0; with OVERLAP=1, history and fill SHALL be kept.
REQ-020 prog SHALL equal the longest k <= fill such that the last k history bits equal pat_reg[WIDTH-1:WIDTH-k].
REQ-021 prog SHALL read WIDTH on a match cycle, and 0 after a match when OVERLAP=0.
REQ-022 On each match, match_cnt SHALL increment by 1 and saturate at 2^CNT_W-1 without wrapping.
REQ-023 With en=0 and load=0, all state SHALL hold and y SHALL be 0 in both modes, apart from the pending Moore pulse.
REQ-024 load=1 SHALL have priority over en: it captures pat, clears history, fill and match_cnt, and forces y=0; the x bit in that cycle is discarded.
REQ-025 Pattern changes on pat without load SHALL have no effect.

Reset
REQ-026 While rst=0, the block SHALL asynchronously clear pattern register, history, fill, match_cnt and the Moore y register.
REQ-027 During and after reset, y SHALL be 0, prog 0 and match_cnt 0.
REQ-028 The pattern register SHALL reset to all zeros, so an explicit load is required before a meaningful match.
REQ-029 Reset asserted mid-stream SHALL discard partial progress and any pending Moore pulse.

Structure
REQ-030 Package seq_detect_pkg SHALL hold the MODE_MEALY=0 and MODE_MOORE=1 constants and a PROG_W(width) helper function.
REQ-031 The longest-suffix/prefix computation SHALL be a combinational sub-module, seq_prefix_len, parameterised by WIDTH.

Verification
REQ-032 WIDTH=4, MODE=0, OVERLAP=1, load pat=1011, stream 1,0,1,1,0,1,1 with en=1 -> y=1 in bit cycles 4 and 7; match_cnt=2.
REQ-033 Same stream with OVERLAP=0 -> y=1 in bit cycle 4 only; prog=0 after bit 4; match_cnt=1.
REQ-034 MODE=1, same as REQ-032 -> y high one cycle after bits 4 and 7, each pulse 1 cycle wide.
REQ-035 pat=1011, bits 1,0,1 then en=0 for 3 cycles then bit 1 -> prog holds 3 during the gap; match on the final bit.
REQ-036 CNT_W=2, pat=11, OVERLAP=1, stream of six 1s -> matches on bits 2..6; match_cnt saturates at 3.
REQ-037 After bits 1,0,1, pulse rst=0 asynchronously mid-cycle -> prog=0, y=0, match_cnt=0 immediately; after reload pat=1011, stream 1011 -> single match.
